irq_ctrl: RTL and testbench

- Interrupt collector directly downstream of the Timer devices and external interrupt pins.
- Latches per-source requests into a pending register and applies a mask.
- Drives the HWInt vector into CP0 plus a single summary IRQ.
- Memory-mapped on the same word-addressed device bus as Timer: Addr[31:2], WE, Din, Dout, with a 4-word register window.

---
 rtl/irq_ctrl.sv | 106 ++++++++++
 tb/tb_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches per-source interrupt requests into PEND, masks them and drives HWInt/IRQ.
// Latency: a rising request sampled at edge t is pending and visible on HWInt/IRQ after edge t.
// Backpressure: none; bus writes never stall pending capture, and Dout is combinational.
//
// Ports: clk/rst_n (synchronous active-low reset), Addr/WE/Din/Dout word-addressed device bus
// (only Addr[3:2], i.e. Addr[1:0] of this port, is decoded), irq_in raw requests,
// HWInt = pend & mask, IRQ = |HWInt.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [29:0]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_in,
    output logic [NSRC-1:0] HWInt,
    output logic            IRQ
);

    localparam logic [1:0] SEL_PEND  = 2'd0;
    localparam logic [1:0] SEL_MASK  = 2'd1;
    localparam logic [1:0] SEL_MODE  = 2'd2;
    localparam logic [1:0] SEL_CLAIM = 2'd3;

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] hit;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC-1:0] pend_nxt;
    logic [1:0]      sel;
    logic            claim_vld;
    logic [2:0]      claim_idx;
    logic            unused_bits;

    assign sel   = Addr[1:0];
    assign rise  = irq_in & ~irq_q;
    assign hit   = pend & mask;
    assign HWInt = hit;
    assign IRQ   = |hit;

    // Upper address bits are decoded by the system bridge; Din is only partly used.
    assign unused_bits = ^{Addr[29:2], Din};

    // Lowest set index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        claim_vld = |hit;
        claim_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hit[i]) claim_idx = 3'(i);
        end
    end

    // Software clears only ever affect edge-mode sources. A CLAIM index >= NSRC
    // never matches any loop index, so such writes fall through harmlessly.
    always_comb begin
        clr      = '0;
        mode_chg = '0;
        if (WE) begin
            case (sel)
                SEL_PEND:  clr      = Din[NSRC-1:0] & mode;
                SEL_MODE:  mode_chg = Din[NSRC-1:0] ^ mode;
                SEL_CLAIM: begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (Din[2:0] == 3'(i)) clr[i] = mode[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // Edge: set beats clear. Level: mirror input. A mode flip drops the bit for one cycle.
    assign pend_nxt = ((mode & (rise | (pend & ~clr))) | (~mode & irq_in)) & ~mode_chg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
            pend  <= pend_nxt;
            if (WE && sel == SEL_MASK) mask <= Din[NSRC-1:0];
            if (WE && sel == SEL_MODE) mode <= Din[NSRC-1:0];
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (sel)
            SEL_PEND:  Dout = 32'(pend);
            SEL_MASK:  Dout = 32'(mask);
            SEL_MODE:  Dout = 32'(mode);
            SEL_CLAIM: Dout = {claim_vld, 28'd0, claim_idx};
            default:   Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run against a per-source reference model.
// Latency: checks are sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable; the DUT never stalls.
module tb_irq_ctrl;

    localparam int NSRC = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [29:0]     Addr = '0;
    logic            WE = 1'b0;
    logic [31:0]     Din = '0;
    logic [31:0]     Dout;
    logic [NSRC-1:0] irq_in = '0;
    logic [NSRC-1:0] HWInt;
    logic            IRQ;

    int total = 0;
    int bad = 0;

    // Reference model state, one entry per source.
    bit m_pend [NSRC];
    bit m_mask [NSRC];
    bit m_mode [NSRC];
    bit m_prev [NSRC];

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Addr   (Addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .irq_in (irq_in),
        .HWInt  (HWInt),
        .IRQ    (IRQ)
    );

    always #5 clk = ~clk;

    // Each source evolves independently from the rules for its mode.
    task automatic model_step();
        int  s;
        bit  rose, cleared, nxt;
        s = int'(Addr[1:0]);
        for (int i = 0; i < NSRC; i++) begin
            if (!rst_n) begin
                m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
            end else begin
                rose    = irq_in[i] && !m_prev[i];
                cleared = m_mode[i] && WE &&
                          ((s == 0 && Din[i]) || (s == 3 && int'(Din[2:0]) == i));
                if (m_mode[i]) nxt = rose || (m_pend[i] && !cleared);
                else           nxt = irq_in[i];
                if (WE && s == 2 && Din[i] != m_mode[i]) nxt = 0;
                if (WE && s == 1) m_mask[i] = Din[i];
                if (WE && s == 2) m_mode[i] = Din[i];
                m_prev[i] = irq_in[i];
                m_pend[i] = nxt;
            end
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] s);
        logic [31:0] r;
        r = 32'd0;
        case (s)
            2'd0: for (int i = 0; i < NSRC; i++) r[i] = m_pend[i];
            2'd1: for (int i = 0; i < NSRC; i++) r[i] = m_mask[i];
            2'd2: for (int i = 0; i < NSRC; i++) r[i] = m_mode[i];
            default: begin
                for (int i = NSRC - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) r = 32'h8000_0000 + 32'(i);
            end
        endcase
        return r;
    endfunction

    function automatic logic [NSRC-1:0] exp_hwint();
        logic [NSRC-1:0] h;
        for (int i = 0; i < NSRC; i++) h[i] = m_pend[i] && m_mask[i];
        return h;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_write(input logic [1:0] s, input logic [31:0] d);
        Addr = {28'd0, s};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] s);
        Addr = {28'd0, s};
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; WE = 1'b0; irq_in = '0; Addr = '0; Din = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; WE = 1'b0; irq_in = 6'h3F;
        tick(); tick();
        for (int s = 0; s < 4; s++) begin
            read_reg(2'(s)); total++;
            if (Dout !== 32'd0) begin bad++; $display("FAIL reset_dout[%0d]: got %h want 0", s, Dout); end
        end
        total++;
        if (IRQ !== 1'b0 || HWInt !== '0) begin bad++; $display("FAIL reset_irq: got IRQ=%b HWInt=%h want 0/0", IRQ, HWInt); end
        rst_n = 1'b1;
        tick();
        read_reg(2'd0); total++;
        if (Dout !== 32'h3F) begin bad++; $display("FAIL reset_release_pend: got %h want 3f", Dout); end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_release_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_edge_claim();
        do_reset();
        bus_write(2'd2, 32'h01);
        bus_write(2'd1, 32'h01);
        irq_in = 6'h01;
        tick();
        irq_in = 6'h00;
        read_reg(2'd0); total++;
        if (Dout !== 32'h01 || IRQ !== 1'b1) begin bad++; $display("FAIL edge_set: got pend=%h irq=%b want 1/1", Dout, IRQ); end
        tick();
        read_reg(2'd0); total++;
        if (Dout !== 32'h01) begin bad++; $display("FAIL edge_hold: got %h want 1", Dout); end
        read_reg(2'd3); total++;
        if (Dout !== 32'h8000_0000) begin bad++; $display("FAIL edge_claim_read: got %h want 80000000", Dout); end
        bus_write(2'd3, 32'd0);
        read_reg(2'd0); total++;
        if (Dout !== 32'h0 || IRQ !== 1'b0) begin bad++; $display("FAIL edge_claimed: got pend=%h irq=%b want 0/0", Dout, IRQ); end
    endtask

    task automatic test_level();
        do_reset();
        bus_write(2'd1, 32'h02);
        irq_in = 6'h02;
        tick();
        total++;
        if (HWInt !== 6'h02) begin bad++; $display("FAIL level_set: got %h want 02", HWInt); end
        bus_write(2'd0, 32'h02);
        total++;
        if (HWInt !== 6'h02) begin bad++; $display("FAIL level_w1c_ignored: got %h want 02", HWInt); end
        irq_in = 6'h00;
        tick();
        total++;
        if (HWInt !== 6'h00) begin bad++; $display("FAIL level_drop: got %h want 00", HWInt); end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(2'd2, 32'h3F);
        bus_write(2'd1, 32'h3F);
        irq_in = 6'h14;
        tick();
        irq_in = 6'h00;
        read_reg(2'd3); total++;
        if (Dout !== 32'h8000_0002) begin bad++; $display("FAIL prio_first: got %h want 80000002", Dout); end
        bus_write(2'd3, 32'd7);
        read_reg(2'd3); total++;
        if (Dout !== 32'h8000_0002) begin bad++; $display("FAIL prio_bad_idx: got %h want 80000002", Dout); end
        bus_write(2'd3, 32'd2);
        read_reg(2'd3); total++;
        if (Dout !== 32'h8000_0004) begin bad++; $display("FAIL prio_second: got %h want 80000004", Dout); end
        bus_write(2'd3, 32'd4);
        read_reg(2'd3); total++;
        if (Dout !== 32'h0) begin bad++; $display("FAIL prio_empty: got %h want 0", Dout); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus_write(2'd2, 32'h3F);
        irq_in = 6'h08;
        tick();
        irq_in = 6'h00;
        tick();
        irq_in = 6'h08;
        bus_write(2'd0, 32'h08);
        read_reg(2'd0); total++;
        if (Dout !== 32'h08) begin bad++; $display("FAIL sim_set_beats_clr: got %h want 08", Dout); end
        irq_in = 6'h00;
        tick();
        irq_in = 6'h01;
        bus_write(2'd1, 32'h01);
        total++;
        if (HWInt !== 6'h01 || IRQ !== 1'b1) begin bad++; $display("FAIL sim_mask_and_rise: got %h/%b want 01/1", HWInt, IRQ); end
        bus_write(2'd1, 32'hFFFF_FFFF);
        read_reg(2'd1); total++;
        if (Dout !== 32'h3F) begin bad++; $display("FAIL mask_upper_bits: got %h want 3f", Dout); end
    endtask

    task automatic test_edge_held();
        do_reset();
        bus_write(2'd2, 32'h3F);
        bus_write(2'd1, 32'h20);
        irq_in = 6'h20;
        tick();
        total++;
        if (HWInt !== 6'h20) begin bad++; $display("FAIL held_set: got %h want 20", HWInt); end
        bus_write(2'd3, 32'd5);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (HWInt !== 6'h00) begin bad++; $display("FAIL held_no_repend[%0d]: got %h want 00", k, HWInt); end
            tick();
        end
        irq_in = 6'h00;
        tick();
        irq_in = 6'h20;
        tick();
        total++;
        if (HWInt !== 6'h20) begin bad++; $display("FAIL held_retoggle: got %h want 20", HWInt); end
        bus_write(2'd2, 32'h1F);
        read_reg(2'd0); total++;
        if (Dout !== 32'h00) begin bad++; $display("FAIL mode_change_clear: got %h want 00", Dout); end
        tick();
        read_reg(2'd0); total++;
        if (Dout !== 32'h20) begin bad++; $display("FAIL mode_change_reload: got %h want 20", Dout); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n  = ($urandom_range(0, 79) != 0);
            irq_in = irq_in ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
            WE     = ($urandom_range(0, 2) == 0);
            Addr   = 30'($urandom);
            Din    = $urandom;
            if ($urandom_range(0, 1) == 0) Din[2:0] = 3'($urandom_range(0, NSRC - 1));
            #1;
            total++;
            if (Dout !== exp_read(Addr[1:0])) begin
                bad++; $display("FAIL rand_dout[%0d] sel=%0d: got %h want %h", n, Addr[1:0], Dout, exp_read(Addr[1:0]));
            end
            total++;
            if (HWInt !== exp_hwint() || IRQ !== (|exp_hwint())) begin
                bad++; $display("FAIL rand_irq[%0d]: got %h/%b want %h/%b", n, HWInt, IRQ, exp_hwint(), |exp_hwint());
            end
            tick();
        end
        rst_n = 1'b1;
        WE    = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_edge_claim();
        test_level();
        test_priority();
        test_simultaneous();
        test_edge_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
